// File: rtl/bsg_host_tx_serializer.sv
// rtl/bsg_host_tx_serializer.sv - splits width_p host words into LSB-first narrow_p link beats
// Define BSG_HOST_TX_CHECKSUM_EN to append an XOR checksum beat after each word.
module bsg_host_tx_serializer #(
  parameter int width_p  = 64,
  parameter int narrow_p = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                v_i,
  input  logic [width_p-1:0]  data_i,
  output logic                ready_o,
  output logic                v_o,
  output logic [narrow_p-1:0] data_o,
  output logic                last_o,
  input  logic                ready_i
);

  localparam int n_lp     = width_p / narrow_p;
  localparam int cnt_w_lp = $clog2(n_lp + 1);
`ifdef BSG_HOST_TX_CHECKSUM_EN
  localparam int final_lp = n_lp;
`else
  localparam int final_lp = n_lp - 1;
`endif

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic [width_p-1:0]  data_q, data_d;
  logic [narrow_p-1:0] beat;
  logic                final_beat;

  // Beat mux sees only registered state, so data_i never reaches data_o combinationally.
  always_comb begin
    beat = '0;
    for (int k = 0; k < n_lp; k++) begin
      if (cnt_q == cnt_w_lp'(k)) beat = data_q[k*narrow_p +: narrow_p];
    end
`ifdef BSG_HOST_TX_CHECKSUM_EN
    if (cnt_q == cnt_w_lp'(n_lp)) begin
      for (int k = 0; k < n_lp; k++) beat = beat ^ data_q[k*narrow_p +: narrow_p];
    end
`endif
  end

  assign final_beat = (cnt_q == cnt_w_lp'(final_lp));
  assign v_o        = (state_q == SEND);
  assign last_o     = v_o & final_beat;
  assign data_o     = v_o ? beat : '0;
  // ready_i -> ready_o is combinational so a new word can follow the last beat without a bubble.
  assign ready_o    = ~reset_i & ((state_q == IDLE) | (v_o & final_beat & ready_i));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (v_i) begin
          data_d  = data_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (final_beat) begin
            cnt_d = '0;
            if (v_i) data_d = data_i;
            else     state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_bsg_host_tx_serializer.sv
// tb/tb_bsg_host_tx_serializer.sv - directed and random checks of bsg_host_tx_serializer
module tb_bsg_host_tx_serializer;

  localparam int N = 4;
`ifdef BSG_HOST_TX_CHECKSUM_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif
  localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] W5 = 64'hAAAA_BBBB_CCCC_DDDD;

  logic        clk = 1'b0;
  logic        reset_i, v_i, ready_o, v_o, last_o, ready_i;
  logic [63:0] data_i;
  logic [15:0] data_o;
  int          n_vec = 0;
  int          n_err = 0;

  bsg_host_tx_serializer #(.width_p(64), .narrow_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .last_o(last_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] beat_of(input logic [63:0] w, input int k);
    logic [15:0] x;
    x = '0;
    if (k < N) return w[k*16 +: 16];
    for (int i = 0; i < N; i++) x = x ^ w[i*16 +: 16];
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] w, input int k);
    chk({tag, "_v"}, 64'(v_o), 64'd1);
    chk({tag, "_data"}, 64'(data_o), 64'(beat_of(w, k)));
    chk({tag, "_last"}, 64'(last_o), 64'(k == NB - 1));
  endtask

  // Word was accepted at the previous edge; walk its beats, optionally stalling one of them.
  task automatic run_word(input string tag, input logic [63:0] w, input int stall_k, input int stall_n);
    for (int k = 0; k < NB; k++) begin
      if (k == stall_k) begin
        ready_i = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          #1;
          chk_beat({tag, "_stall"}, w, k);
          chk({tag, "_stall_rdy"}, 64'(ready_o), 64'd0);
          step();
        end
        ready_i = 1'b1;
      end
      #1;
      chk_beat(tag, w, k);
      chk({tag, "_rdy"}, 64'(ready_o), 64'(k == NB - 1));
      step();
    end
    #1;
    chk({tag, "_idle_v"}, 64'(v_o), 64'd0);
  endtask

  logic [63:0] q[$];
  logic [63:0] asm_w, exp_w;
  logic [15:0] xs, pd;
  bit          pstall, pl, acc;
  int          bi, win, wout, cyc;

  initial begin
    reset_i = 1'b1; v_i = 1'b0; ready_i = 1'b1; data_i = '0;
    #3;
    chk("rst_v", 64'(v_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_rdy", 64'(ready_o), 64'd0);
    repeat (2) @(posedge clk);
    #4;
    reset_i = 1'b0;
    #1;
    chk("rel_rdy", 64'(ready_o), 64'd1);
    chk("rel_v", 64'(v_o), 64'd0);

    // single word
    step(); v_i = 1'b1; data_i = W1;
    #1 chk("t1_accept", 64'(ready_o), 64'd1);
    step(); v_i = 1'b0;
    run_word("t1", W1, -1, 0);

    // backpressure on beat 1
    step(); v_i = 1'b1; data_i = W1;
    step(); v_i = 1'b0;
    run_word("t3", W1, 1, 3);

    // back-to-back words, second accepted on first word's last handshake
    step(); v_i = 1'b1; data_i = 64'd1;
    #1 chk("t2_accept", 64'(ready_o), 64'd1);
    step(); data_i = 64'd2;
    for (int k = 0; k < NB; k++) begin
      #1;
      chk_beat("t2a", 64'd1, k);
      chk("t2a_rdy", 64'(ready_o), 64'(k == NB - 1));
      step();
    end
    v_i = 1'b0;
    run_word("t2b", 64'd2, -1, 0);

    // asynchronous reset after beat 1
    step(); v_i = 1'b1; data_i = W1;
    step(); v_i = 1'b0;
    #1 chk_beat("t5_pre0", W1, 0);
    step();
    #1 chk_beat("t5_pre1", W1, 1);
    step();
    #1 chk_beat("t5_pre2", W1, 2);
    #3 reset_i = 1'b1;
    #1;
    chk("t5_rst_v", 64'(v_o), 64'd0);
    chk("t5_rst_last", 64'(last_o), 64'd0);
    chk("t5_rst_data", 64'(data_o), 64'd0);
    chk("t5_rst_rdy", 64'(ready_o), 64'd0);
    @(posedge clk);
    #4 chk("t5_hold_v", 64'(v_o), 64'd0);
    #2 reset_i = 1'b0;
    #1;
    chk("t5_rel_rdy", 64'(ready_o), 64'd1);
    chk("t5_rel_v", 64'(v_o), 64'd0);
    step(); v_i = 1'b1; data_i = W5;
    step(); v_i = 1'b0;
    run_word("t5", W5, -1, 0);

    // random traffic with scoreboard
    step();
    v_i = 1'b0; pstall = 1'b0; pl = 1'b0; pd = '0; acc = 1'b0;
    bi = 0; win = 0; wout = 0; cyc = 0; xs = '0; asm_w = '0;
    while (wout < 1000 && cyc < 40000) begin
      if (!v_i && win < 1000 && $urandom_range(0, 1) == 1) begin
        v_i = 1'b1;
        data_i = {$urandom, $urandom};
      end
      ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (pstall) chk("rnd_hold", 64'({v_o, last_o, data_o}), 64'({1'b1, pl, pd}));
      if (v_i && ready_o) begin
        q.push_back(data_i);
        win++;
        acc = 1'b1;
      end
      if (v_o && ready_i) begin
        if (bi < N) begin
          asm_w[bi*16 +: 16] = data_o;
          xs = xs ^ data_o;
        end else begin
          chk("rnd_csum", 64'(data_o), 64'(xs));
        end
        chk("rnd_last", 64'(last_o), 64'(bi == NB - 1));
        if (last_o) begin
          if (q.size() == 0) begin
            chk("rnd_underflow", 64'd1, 64'd0);
          end else begin
            exp_w = q.pop_front();
            chk("rnd_word", asm_w, exp_w);
          end
          wout++;
          bi = 0;
          xs = '0;
        end else begin
          bi++;
        end
      end
      pstall = v_o && !ready_i;
      pl = last_o;
      pd = data_o;
      step();
      if (acc) begin
        v_i = 1'b0;
        acc = 1'b0;
      end
      cyc++;
    end
    chk("rnd_done", 64'(wout), 64'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
